// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_TAG_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_bit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_bit ? {1'b0, i_opnd} : {(WIDTH + 1){1'b0}});
    w_shift = {i_acc, i_bit};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    w_diff  = w_shift - {1'b0, i_opnd};
    if (i_op == OP_MUL) begin
      o_acc = w_sum[WIDTH:1];
      o_bit = w_sum[0];
    end else if (!w_diff[WIDTH]) begin
      o_acc = w_diff[WIDTH-1:0];
      o_bit = 1'b1;
    end else begin
      o_acc = w_shift[WIDTH-1:0];
      o_bit = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Bit-serial unsigned multiply/divide unit with pipeline stall, flush and tagged writeback.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_mult,
  input  logic             i_req_div,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_lo,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [TAG_W-1:0] r_tag, w_tag_nxt;
  logic [WIDTH-1:0] r_res_lo, w_res_lo_nxt;
  logic [WIDTH-1:0] r_res_hi, w_res_hi_nxt;
  logic [TAG_W-1:0] r_res_tag, w_res_tag_nxt;
  logic             r_dbz, w_dbz_nxt;

  op_t              w_op;
  logic             w_step_bit;
  logic [WIDTH-1:0] w_step_acc;
  logic             w_accept;

  assign w_op = (r_state == ST_DIV) ? OP_DIV : OP_MUL;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_op  (w_op),
    .i_acc (r_acc),
    .i_opnd(r_opnd),
    .i_bit ((w_op == OP_MUL) ? r_shift[0] : r_shift[WIDTH-1]),
    .o_acc (w_step_acc),
    .o_bit (w_step_bit)
  );

  assign o_busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign o_req_ready = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !i_flush;
  assign o_stall     = (i_req_valid && !o_req_ready) || o_busy;
  assign o_done      = (r_state == ST_DONE);
  assign w_accept    = i_req_valid && o_req_ready && (i_req_mult || i_req_div);

  assign o_res_lo      = r_res_lo;
  assign o_res_hi      = r_res_hi;
  assign o_res_tag     = r_res_tag;
  assign o_div_by_zero = r_dbz;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_opnd_nxt    = r_opnd;
    w_acc_nxt     = r_acc;
    w_shift_nxt   = r_shift;
    w_tag_nxt     = r_tag;
    w_res_lo_nxt  = r_res_lo;
    w_res_hi_nxt  = r_res_hi;
    w_res_tag_nxt = r_res_tag;
    w_dbz_nxt     = r_dbz;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_tag_nxt = i_req_tag;
      w_cnt_nxt = '0;
      w_acc_nxt = '0;
      if (i_req_mult) begin
        w_state_nxt = ST_MUL;
        w_opnd_nxt  = i_req_a;
        w_shift_nxt = i_req_b;
      end else begin
        w_opnd_nxt  = i_req_b;
        w_shift_nxt = i_req_a;
        if (i_req_b == '0) begin
          // Divide by zero resolves immediately without iterating.
          w_state_nxt   = ST_DONE;
          w_res_lo_nxt  = '1;
          w_res_hi_nxt  = i_req_a;
          w_res_tag_nxt = i_req_tag;
          w_dbz_nxt     = 1'b1;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
    end else begin
      case (r_state)
        ST_MUL, ST_DIV: begin
          w_acc_nxt   = w_step_acc;
          w_shift_nxt = (w_op == OP_MUL) ? {w_step_bit, r_shift[WIDTH-1:1]}
                                         : {r_shift[WIDTH-2:0], w_step_bit};
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt   = ST_DONE;
            w_res_hi_nxt  = w_step_acc;
            w_res_lo_nxt  = w_shift_nxt;
            w_res_tag_nxt = r_tag;
            w_dbz_nxt     = 1'b0;
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_tag     <= '0;
      r_res_lo  <= '0;
      r_res_hi  <= '0;
      r_res_tag <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_opnd    <= w_opnd_nxt;
      r_acc     <= w_acc_nxt;
      r_shift   <= w_shift_nxt;
      r_tag     <= w_tag_nxt;
      r_res_lo  <= w_res_lo_nxt;
      r_res_hi  <= w_res_hi_nxt;
      r_res_tag <= w_res_tag_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

endmodule
